// File: rtl/floor_display.sv
// Floor indicator driver: debounces the floor code over STABLE_CYCLES samples and maps invalid codes.
// Optional macro FLOOR_DISPLAY_HOLD_EN keeps the last display on a stable invalid code instead of showing ERR_CODE.
module floor_display #(
    parameter int unsigned NUM_FLOORS    = 5,
    parameter logic [3:0]  ERR_CODE      = 4'hE,
    parameter int unsigned STABLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] floor,
    output logic [3:0] display
);

    localparam logic [3:0] NUM_FLOORS_L = 4'(NUM_FLOORS);
    localparam logic [3:0] STABLE_L     = 4'(STABLE_CYCLES);

    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] display_q, display_d;

    function automatic logic floor_valid(input logic [3:0] f);
        return (f < NUM_FLOORS_L);
    endfunction

    always_comb begin
        cand_d    = floor;
        cnt_d     = 4'd1;
        display_d = display_q;

        // Run length of identical samples, saturating so a steady input keeps qualifying.
        if (floor == cand_q) begin
            cnt_d = (cnt_q >= STABLE_L) ? STABLE_L : cnt_q + 4'd1;
        end

        if (cnt_d == STABLE_L) begin
            if (floor_valid(floor)) begin
                display_d = floor;
            end else begin
`ifdef FLOOR_DISPLAY_HOLD_EN
                display_d = display_q;
`else
                display_d = ERR_CODE;
`endif
            end
        end
    end

    // Reset leaves floor 0 already qualified as stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q    <= 4'h0;
            cnt_q     <= STABLE_L;
            display_q <= 4'h0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            display_q <= display_d;
        end
    end

    assign display = display_q;

endmodule

// File: tb/tb_floor_display.sv
// Bench for floor_display: a 1-cycle and a 3-cycle debounce instance run side by side against a sample-window model.
module tb_floor_display;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] floor = 4'h0;
    logic [3:0] disp1;
    logic [3:0] disp3;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int NF  = 5;
    localparam int ERR = 14;
`ifdef FLOOR_DISPLAY_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    always #5 clk = ~clk;

    floor_display u_dut1 (
        .clk     (clk),
        .reset   (reset),
        .floor   (floor),
        .display (disp1)
    );

    floor_display #(.STABLE_CYCLES(3)) u_dut3 (
        .clk     (clk),
        .reset   (reset),
        .floor   (floor),
        .display (disp3)
    );

    // Model: display takes the mapped floor whenever the last S samples were all that floor.
    int sc[2] = '{1, 3};
    int hist[2][16];
    int exp_d[2];
    bit model_ok = 1'b0;
    bit stable_m;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                for (int k = 0; k < 16; k++) hist[d][k] = 0;
                exp_d[d] = 0;
            end else begin
                for (int k = 15; k > 0; k--) hist[d][k] = hist[d][k-1];
                hist[d][0] = int'(floor);
                stable_m = 1'b1;
                for (int k = 0; k < sc[d]; k++)
                    if (hist[d][k] != int'(floor)) stable_m = 1'b0;
                if (stable_m) begin
                    if (int'(floor) < NF) exp_d[d] = int'(floor);
                    else if (!HOLD) exp_d[d] = ERR;
                end
            end
        end
        if (reset) model_ok = 1'b1;
    end

    task automatic check(input string name, input logic [3:0] act, input int exp);
        n_cmp++;
        if (act !== 4'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (model_ok) begin
            check("model_s1", disp1, exp_d[0]);
            check("model_s3", disp3, exp_d[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int inv_exp;

    initial begin
        inv_exp = HOLD ? 4 : ERR;

        reset = 1'b1; floor = 4'h0;
        tick();
        check("rst_s1", disp1, 0);
        check("rst_s3", disp3, 0);
        reset = 1'b0;
        tick();
        check("rel_s1", disp1, 0);
        check("rel_s3", disp3, 0);

        for (int f = 1; f < 5; f++) begin
            floor = 4'(f);
            tick();
            check("step_first", disp1, f);
            tick();
            check("step_hold", disp1, f);
        end

        floor = 4'h5;
        tick();
        check("inv5_a", disp1, inv_exp);
        tick();
        check("inv5_b", disp1, inv_exp);
        floor = 4'hF;
        tick();
        check("invF", disp1, inv_exp);
        floor = 4'h2;
        tick();
        check("recover2", disp1, 2);

        reset = 1'b1; floor = 4'h0;
        tick();
        reset = 1'b0;
        floor = 4'h1;
        tick();
        check("s3_one_a", disp3, 0);
        tick();
        check("s3_one_b", disp3, 0);
        floor = 4'h2;
        tick();
        check("s3_two_a", disp3, 0);
        tick();
        check("s3_two_b", disp3, 0);
        tick();
        check("s3_two_c", disp3, 2);

        floor = 4'h3;
        repeat (3) tick();
        check("pre_rst_s3", disp3, 3);
        check("pre_rst_s1", disp1, 3);
        floor = 4'h1;
        tick();
        check("mid_s3", disp3, 3);
        check("mid_s1", disp1, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_s3", disp3, 0);
        check("mid_rst_s1", disp1, 0);
        reset = 1'b0;
        tick();
        check("restart_a", disp3, 0);
        tick();
        check("restart_b", disp3, 0);
        tick();
        check("restart_c", disp3, 1);

        for (int c = 0; c < 16; c++) begin
            floor = 4'(c);
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            floor = 4'(c);
            repeat (3) tick();
        end

        floor = 4'h4;
        repeat (3) tick();
        floor = 4'h9;
        repeat (3) tick();
        check("vi_s3", disp3, inv_exp);
        floor = 4'h0;
        repeat (3) tick();
        check("iv_s3", disp3, 0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
